mod_addsub_pipe: RTL
====================

Name: mod_addsub_pipe

Overview:
- Two-stage pipelined modular adder/subtractor: computes (a ± b) mod q for operands already in [0, q-1].
- Stage 1 forms the signed raw sum/difference.
- Stage 2 derives the two comparison flags (raw ≥ 0, raw ≥ q) and applies a single ±q correction.
- Valid/ready handshake on both sides; full back-pressure support, so the block drops into a streaming datapath.

Parameters:
- W, 4, operand/modulus width (unsigned); internal raw path is W+2 bits signed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  upstream presents a transaction
- in_ready  output  1  block can accept this cycle
- in_a  input  W  operand a, unsigned
- in_b  input  W  operand b, unsigned
- in_q  input  W  modulus for this transaction, unsigned
- in_sub  input  1  0 = a+b, 1 = a−b
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts
- out_res  output  W  (a ± b) mod q
- out_err  output  1  transaction invalid (q==0, a≥q or b≥q)

Behaviour:
- Reset: sampled on clk edge while rst_n==0. Clears s1_valid and out_valid to 0, out_res to 0, out_err to 0. Stage data registers are don't-care.
- A transfer occurs on any edge with valid && ready, on either port.
- Stall/advance rules:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational, no combinational path from in_valid.
- Stage 1, on adv1: s1_valid <= in_valid. When in_valid, capture:
  - raw = sub ? (a − b) : (a + b), sign-extended to W+2.
  - q, sub.
  - err = (q==0) || (a≥q) || (b≥q).
- Stage 2, on adv2: out_valid <= s1_valid. When s1_valid:
  - ge0 = (raw ≥ 0); geq = (raw ≥ q), signed compare with q zero-extended.
  - add: res = geq ? raw − q : raw.
  - sub: res = ge0 ? raw : raw + q.
  - out_res <= res[W-1:0]; out_err <= err.
  - If err: out_res <= 0 and out_err <= 1.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1 per cycle.
- Hold: while out_valid && !out_ready, out_res and out_err stay stable. Stage 1 holds if occupied; in_ready drops only when both stages are full.
- Simultaneous events: same-edge out transfer and in transfer are legal; the pipeline shifts with no bubble.
- Bubbles: when in_valid==0 on an advance, s1_valid goes 0; the data registers may hold stale values.
- Reset mid-operation: all in-flight transactions are discarded. No out_valid in the cycle after reset release. in_ready==1 in the first cycle after release.
- Arithmetic range: raw ∈ [−(2^W−1), 2^(W+1)−2] fits W+2 signed. The corrected result is always in [0, q−1] for valid inputs.

Test Plan:
- Add with wrap: W=4, q=13, a=7, b=9, add, out_ready=1 -> raw 16, out_res=3, out_err=0, out_valid 2 cycles after transfer.
- Subtract underflow: q=13, a=3, b=9, sub -> raw −6, out_res=7; boundaries:
  - a=0, b=0, sub -> 0.
  - a=12, b=12, add -> 11.
  - q=15, a=14, b=14, add -> 13.
- Errors:
  - q=13, a=14, b=1 -> out_err=1, out_res=0.
  - q=0, a=0, b=0 -> out_err=1.
- Back-pressure: stream 4 back-to-back transactions with out_ready=0 for 3 cycles. Required:
  - in_ready falls after 2 accepted.
  - out_res held stable.
  - After out_ready returns, all 4 results emerge in order with no loss or duplication.
- Full-rate: out_ready=1, in_valid=1 for 16 cycles with random valid operands -> 16 results, one per cycle, matching a reference model ((a±b) mod q).
- Reset mid-flight: 2 transactions in the pipe, rst_n=0 for 1 cycle -> out_valid=0, out_res=0, out_err=0 after the edge. Nothing emitted after release until new input.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor: out_res = (in_a +/- in_b) mod in_q.
// Stage 1 forms the signed raw value; stage 2 applies a single +/-q correction.
`timescale 1ns/1ps
module mod_addsub_pipe #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_q,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_err
);

  localparam int RW = W + 2;

  logic                 adv1;
  logic                 adv2;

  logic                 s1_valid_q;
  logic signed [RW-1:0] s1_raw_q;
  logic signed [RW-1:0] s1_raw_d;
  logic [W-1:0]         s1_mod_q;
  logic                 s1_sub_q;
  logic                 s1_err_q;
  logic                 s1_err_d;

  logic                 out_valid_q;
  logic [W-1:0]         out_res_q;
  logic [W-1:0]         out_res_d;
  logic                 out_err_q;

  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic signed [RW-1:0] q_ext;
  logic                 ge0;
  logic                 geq;

  // Stage 2 frees up when empty or draining; stage 1 when empty or shifting.
  assign adv2      = !out_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_err   = out_err_q;

  always_comb begin
    a_ext    = {2'b00, in_a};
    b_ext    = {2'b00, in_b};
    s1_raw_d = in_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    s1_err_d = (in_q == '0) || (in_a >= in_q) || (in_b >= in_q);
  end

  // Raw spans [-(2^W-1), 2^(W+1)-2], so one signed compare against q
  // (or against zero) decides the single correction step.
  always_comb begin
    q_ext = {2'b00, s1_mod_q};
    ge0   = !s1_raw_q[RW-1];
    geq   = (s1_raw_q >= q_ext);
    if (s1_sub_q) begin
      out_res_d = ge0 ? W'(s1_raw_q) : W'(s1_raw_q + q_ext);
    end else begin
      out_res_d = geq ? W'(s1_raw_q - q_ext) : W'(s1_raw_q);
    end
    if (s1_err_q) begin
      out_res_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_res_q <= out_res_d;
          out_err_q <= s1_err_q;
        end
      end
    end
  end

  // NOTE: stage-1 data is qualified by s1_valid_q, so it carries no reset
  // and keeps stale values across bubbles.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_raw_q <= s1_raw_d;
      s1_mod_q <= in_q;
      s1_sub_q <= in_sub;
      s1_err_q <= s1_err_d;
    end
  end

endmodule
